// File: rtl/wm_actuator_if.sv
// Stage lamps from the washing-machine controller and the actuator commands driven back,
// bundled so the driver and its environment share one connection point.
interface wm_actuator_if;
   logic [7:0] stage;
   logic       fill;
   logic       drain;
   logic       lock;
   logic       motorCw;
   logic       motorCcw;
   logic       pwm;
   logic       fault;

   modport master (output stage, input fill, drain, lock, motorCw, motorCcw, pwm, fault);
   modport slave  (input stage, output fill, drain, lock, motorCw, motorCcw, pwm, fault);
endinterface

// File: rtl/wm_actuator_driver.sv
// Turns one-hot wash stages into timed valve, pump, lock and PWM motor commands, with
// direction dead-time protection and a sticky fault for malformed stage vectors.
module wm_actuator_driver #(
   parameter int FILL_CYC  = 8,
   parameter int DRAIN_CYC = 6,
   parameter int AGIT_CYC  = 4,
   parameter int DEAD_CYC  = 2,
   parameter int AGIT_DUTY = 8,
   parameter int RAMP_CYC  = 2,
   parameter int PWM_W     = 4,
   parameter int CNT_W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   wm_actuator_if.slave bus
);
   typedef enum logic [3:0] {
      P_OFF, P_FILL, P_DRAIN, P_CW, P_DEAD_A, P_CCW, P_DEAD_B, P_SPIN, P_HOLD
   } phase_e;

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
   localparam logic [CNT_W-1:0] AGIT_LAST  = CNT_W'(AGIT_CYC - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'(RAMP_CYC - 1);
   localparam logic [CNT_W-1:0] DEAD_MIN   = CNT_W'(DEAD_CYC);
   localparam logic [PWM_W-1:0] DUTY_MAX   = '1;
   localparam logic [PWM_W-1:0] AGIT_D     = PWM_W'(AGIT_DUTY);

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, offCnt_q, offCnt_d;
   logic [PWM_W-1:0] duty_q, duty_d, pwmCnt_q, dutyUse;
   logic [7:0]       lamps_q, prevLamps_q;
   logic             sampled_q, oneHot, cwSafe, ccwSafe;
   logic             dirSeen_q, dirSeen_d, lastCcw_q, lastCcw_d;
   logic             fill_q, fill_d, drain_q, drain_d, lock_q, lock_d;
   logic             cw_q, cw_d, ccw_q, ccw_d, pwm_q, pwm_d, fault_q, fault_d;

   // Phase sequencing: a stage change restarts its first phase and beats any timer expiry.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      duty_d  = duty_q;
      if (!sampled_q) begin
         cnt_d = cnt_q;
      end else if (lamps_q != prevLamps_q) begin
         cnt_d  = '0;
         duty_d = '0;
         case (lamps_q)
            8'b0000_0010:               phase_d = P_FILL;
            8'b0000_0100, 8'b0001_0000: phase_d = P_CW;
            8'b0000_1000, 8'b0010_0000: phase_d = P_DRAIN;
            8'b0100_0000:               phase_d = P_SPIN;
            8'b1000_0000:               phase_d = P_HOLD;
            default:                    phase_d = P_OFF;
         endcase
      end else begin
         case (phase_q)
            P_FILL:   if (cnt_q >= FILL_LAST)  begin cnt_d = '0; phase_d = lamps_q[1] ? P_HOLD : P_CW; end
            P_DRAIN:  if (cnt_q >= DRAIN_LAST) begin cnt_d = '0; phase_d = P_FILL;   end
            P_CW:     if (cnt_q >= AGIT_LAST)  begin cnt_d = '0; phase_d = P_DEAD_A; end
            P_DEAD_A: if (cnt_q >= DEAD_LAST)  begin cnt_d = '0; phase_d = P_CCW;    end
            P_CCW:    if (cnt_q >= AGIT_LAST)  begin cnt_d = '0; phase_d = P_DEAD_B; end
            P_DEAD_B: if (cnt_q >= DEAD_LAST)  begin cnt_d = '0; phase_d = P_CW;     end
            P_SPIN: begin
               if (cnt_q >= RAMP_LAST) begin
                  cnt_d = '0;
                  if (duty_q != DUTY_MAX) duty_d = duty_q + PWM_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Actuator outputs; a reversal is held off until the motor has been idle for DEAD_CYC
   // cycles, which also covers stage switches that land mid-stroke.
   always_comb begin
      oneHot  = (lamps_q != '0) && ((lamps_q & (lamps_q - 8'd1)) == '0);
      fault_d = fault_q;
      if (sampled_q) begin
         fault_d = fault_q ? (lamps_q != 8'h01) : !oneHot;
      end
      cwSafe    = !dirSeen_q || !lastCcw_q || (offCnt_q >= DEAD_MIN);
      ccwSafe   = !dirSeen_q || lastCcw_q || (offCnt_q >= DEAD_MIN);
      cw_d      = !fault_d && cwSafe && (phase_d == P_CW || phase_d == P_SPIN);
      ccw_d     = !fault_d && ccwSafe && (phase_d == P_CCW);
      fill_d    = !fault_d && (phase_d == P_FILL);
      drain_d   = !fault_d && (phase_d == P_DRAIN || phase_d == P_SPIN);
      lock_d    = fault_d ? lock_q : (lamps_q[7:1] != 7'd0);
      dutyUse   = (phase_d == P_SPIN) ? duty_d : AGIT_D;
      pwm_d     = (cw_d || ccw_d) && (pwmCnt_q < dutyUse);
      offCnt_d  = (cw_d || ccw_d) ? '0 : ((offCnt_q == CNT_MAX) ? offCnt_q : offCnt_q + CNT_W'(1));
      dirSeen_d = dirSeen_q || cw_d || ccw_d;
      lastCcw_d = ccw_d ? 1'b1 : (cw_d ? 1'b0 : lastCcw_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lamps_q     <= '0;
         prevLamps_q <= '0;
         sampled_q   <= 1'b0;
         phase_q     <= P_OFF;
         cnt_q       <= '0;
         duty_q      <= '0;
         pwmCnt_q    <= '0;
         offCnt_q    <= '0;
         dirSeen_q   <= 1'b0;
         lastCcw_q   <= 1'b0;
         fill_q      <= 1'b0;
         drain_q     <= 1'b0;
         lock_q      <= 1'b0;
         cw_q        <= 1'b0;
         ccw_q       <= 1'b0;
         pwm_q       <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         lamps_q     <= bus.stage;
         prevLamps_q <= lamps_q;
         sampled_q   <= 1'b1;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         duty_q      <= duty_d;
         pwmCnt_q    <= pwmCnt_q + PWM_W'(1);
         offCnt_q    <= offCnt_d;
         dirSeen_q   <= dirSeen_d;
         lastCcw_q   <= lastCcw_d;
         fill_q      <= fill_d;
         drain_q     <= drain_d;
         lock_q      <= lock_d;
         cw_q        <= cw_d;
         ccw_q       <= ccw_d;
         pwm_q       <= pwm_d;
         fault_q     <= fault_d;
      end
   end

   assign bus.fill     = fill_q;
   assign bus.drain    = drain_q;
   assign bus.lock     = lock_q;
   assign bus.motorCw  = cw_q;
   assign bus.motorCcw = ccw_q;
   assign bus.pwm      = pwm_q;
   assign bus.fault    = fault_q;
endmodule
